// File: rtl/raster_pkg.sv
// Shared definitions for the line raster engine: FSM encoding, FIFO word layout
// and the extra width carried by the signed Bresenham error terms.
package raster_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPop,
    StLoad,
    StDraw
  } state_e;

  // Signed error terms are CW + ErrPad bits wide.
  localparam int unsigned ErrPad = 2;

  localparam int unsigned ValidBit = 0;
  localparam int unsigned ColorLsb = 1;

  // Coordinate field index, counted upward from just above the colour field.
  localparam int unsigned CoordY1 = 0;
  localparam int unsigned CoordX1 = 1;
  localparam int unsigned CoordY0 = 2;
  localparam int unsigned CoordX0 = 3;

  function automatic int unsigned coord_lsb(int unsigned idx, int unsigned cw,
                                            int unsigned colw);
    return ColorLsb + colw + idx * cw;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// Bresenham stepper: holds the current point and error term, advances one
// pixel per adv_i and flags when the current point is the line end.
module bresenham_step
  import raster_pkg::*;
#(
  parameter int unsigned CW = 10,
  localparam int unsigned EW = CW + ErrPad
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [CW-1:0] x0_i,
  input  logic [CW-1:0] y0_i,
  input  logic [CW-1:0] x1_i,
  input  logic [CW-1:0] y1_i,
  output logic [CW-1:0] cx_o,
  output logic [CW-1:0] cy_o,
  output logic          last_o
);

  logic signed [EW-1:0] ddx, ddy, adx, ady, e2, err_step;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic [CW-1:0]        cx_q, cy_q, x1_q, y1_q, cx_step, cy_step;
  logic                 sx_neg_q, sy_neg_q;

  always_comb begin
    ddx = $signed({{ErrPad{1'b0}}, x1_i}) - $signed({{ErrPad{1'b0}}, x0_i});
    ddy = $signed({{ErrPad{1'b0}}, y1_i}) - $signed({{ErrPad{1'b0}}, y0_i});
    adx = ddx[EW-1] ? -ddx : ddx;
    ady = ddy[EW-1] ? -ddy : ddy;
  end

  // Both axis updates are decided from the same e2 and may apply together.
  always_comb begin
    e2       = err_q <<< 1;
    err_step = err_q;
    cx_step  = cx_q;
    cy_step  = cy_q;
    if (e2 >= dy_q) begin
      err_step = err_step + dy_q;
      cx_step  = sx_neg_q ? cx_q - CW'(1) : cx_q + CW'(1);
    end
    if (e2 <= dx_q) begin
      err_step = err_step + dx_q;
      cy_step  = sy_neg_q ? cy_q - CW'(1) : cy_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx_q     <= '0;
      cy_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else if (load_i) begin
      cx_q     <= x0_i;
      cy_q     <= y0_i;
      x1_q     <= x1_i;
      y1_q     <= y1_i;
      dx_q     <= adx;
      dy_q     <= -ady;
      err_q    <= adx - ady;
      sx_neg_q <= (x1_i < x0_i);
      sy_neg_q <= (y1_i < y0_i);
    end else if (adv_i) begin
      cx_q  <= cx_step;
      cy_q  <= cy_step;
      err_q <= err_step;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == x1_q) && (cy_q == y1_q);

endmodule

// File: rtl/line_raster_engine.sv
// Line rasterizer between the clipper's line FIFO and the frame buffer: optional
// screen clear, then one frame-buffer write per in-bounds pixel of each line.
module line_raster_engine
  import raster_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned CW    = 10,
  parameter int unsigned COLW  = 3,
  localparam int unsigned LW   = 4 * CW + COLW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LW-1:0]   fifo_data_i,
  input  logic            fifo_empty_i,
  output logic            fifo_rd_en_o,
  input  logic            frame_start_i,
  input  logic            eoo_i,
  input  logic            clr_req_i,
  input  logic [COLW-1:0] bk_color_i,
  input  logic            fb_ready_i,
  output logic            fb_wr_en_o,
  output logic [CW-1:0]   fb_x_o,
  output logic [CW-1:0]   fb_y_o,
  output logic [COLW-1:0] fb_color_o,
  output logic            busy_o,
  output logic            raster_done_o
);

  localparam int unsigned X0Lsb = coord_lsb(CoordX0, CW, COLW);
  localparam int unsigned Y0Lsb = coord_lsb(CoordY0, CW, COLW);
  localparam int unsigned X1Lsb = coord_lsb(CoordX1, CW, COLW);
  localparam int unsigned Y1Lsb = coord_lsb(CoordY1, CW, COLW);

  localparam logic [CW-1:0] XLast = CW'(H_RES - 1);
  localparam logic [CW-1:0] YLast = CW'(V_RES - 1);
  // One extra bit so a resolution of exactly 2**CW still compares correctly.
  localparam logic [CW:0]   XLim  = (CW + 1)'(H_RES);
  localparam logic [CW:0]   YLim  = (CW + 1)'(V_RES);

  state_e          state_q;
  logic [CW-1:0]   clr_x_q, clr_y_q;
  logic [COLW-1:0] color_q;

  logic [CW-1:0]   cx, cy;
  logic            last, in_bounds, fire, adv, load, line_valid;

  assign line_valid = fifo_data_i[ValidBit];
  assign load       = (state_q == StLoad) && line_valid;
  assign in_bounds  = ({1'b0, cx} < XLim) && ({1'b0, cy} < YLim);
  // A skipped pixel has no write pending, so it retires without fb_ready.
  assign fire       = fb_ready_i || !fb_wr_en_o;
  assign adv        = (state_q == StDraw) && fire && !last;

  bresenham_step #(
    .CW(CW)
  ) u_step (
    .clk   (clk),
    .rst   (rst),
    .load_i(load),
    .adv_i (adv),
    .x0_i  (fifo_data_i[X0Lsb +: CW]),
    .y0_i  (fifo_data_i[Y0Lsb +: CW]),
    .x1_i  (fifo_data_i[X1Lsb +: CW]),
    .y1_i  (fifo_data_i[Y1Lsb +: CW]),
    .cx_o  (cx),
    .cy_o  (cy),
    .last_o(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      clr_x_q <= '0;
      clr_y_q <= '0;
      color_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start_i) begin
            clr_x_q <= '0;
            clr_y_q <= '0;
            if (clr_req_i) begin
              color_q <= bk_color_i;
              state_q <= StClear;
            end else begin
              state_q <= StPop;
            end
          end
        end
        StClear: begin
          if (fb_ready_i) begin
            if (clr_x_q == XLast) begin
              clr_x_q <= '0;
              if (clr_y_q == YLast) begin
                state_q <= StPop;
              end else begin
                clr_y_q <= clr_y_q + CW'(1);
              end
            end else begin
              clr_x_q <= clr_x_q + CW'(1);
            end
          end
        end
        StPop: begin
          if (!fifo_empty_i) begin
            state_q <= StLoad;
          end else if (eoo_i) begin
            state_q <= StIdle;
          end
        end
        StLoad: begin
          if (line_valid) begin
            color_q <= fifo_data_i[ColorLsb +: COLW];
            state_q <= StDraw;
          end else begin
            state_q <= StPop;
          end
        end
        StDraw: begin
          if (fire && last) begin
            state_q <= StPop;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    fb_wr_en_o = 1'b0;
    fb_x_o     = '0;
    fb_y_o     = '0;
    fb_color_o = '0;
    unique case (state_q)
      StClear: begin
        fb_wr_en_o = 1'b1;
        fb_x_o     = clr_x_q;
        fb_y_o     = clr_y_q;
        fb_color_o = color_q;
      end
      StDraw: begin
        fb_wr_en_o = in_bounds;
        fb_x_o     = cx;
        fb_y_o     = cy;
        fb_color_o = color_q;
      end
      default: ;
    endcase
  end

  assign busy_o        = (state_q != StIdle);
  assign fifo_rd_en_o  = (state_q == StPop) && !fifo_empty_i;
  assign raster_done_o = (state_q == StPop) && fifo_empty_i && eoo_i;

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine on an 8x4 screen with a small FIFO model.
module tb_line_raster_engine;

  localparam int unsigned H_RES = 8;
  localparam int unsigned V_RES = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned COLW  = 3;
  localparam int unsigned LW    = 4 * CW + COLW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [LW-1:0]   fifo_data = '0;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic            frame_start = 1'b0;
  logic            eoo = 1'b0;
  logic            clr_req = 1'b0;
  logic [COLW-1:0] bk_color = '0;
  logic            fb_ready = 1'b1;
  logic            fb_wr_en;
  logic [CW-1:0]   fb_x, fb_y;
  logic [COLW-1:0] fb_color;
  logic            busy, raster_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [LW-1:0] fmem [16];
  int f_wr = 0;
  int f_rd = 0;

  int wx [256];
  int wy [256];
  int wc [256];
  int n_wr   = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  line_raster_engine #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .CW   (CW),
    .COLW (COLW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .frame_start_i(frame_start),
    .eoo_i        (eoo),
    .clr_req_i    (clr_req),
    .bk_color_i   (bk_color),
    .fb_ready_i   (fb_ready),
    .fb_wr_en_o   (fb_wr_en),
    .fb_x_o       (fb_x),
    .fb_y_o       (fb_y),
    .fb_color_o   (fb_color),
    .busy_o       (busy),
    .raster_done_o(raster_done)
  );

  // Line FIFO: popped word appears on fifo_data one cycle after the strobe.
  assign fifo_empty = (f_wr == f_rd);
  always @(posedge clk) begin
    if (fifo_rd_en && (f_wr != f_rd)) begin
      fifo_data <= fmem[f_rd[3:0]];
      f_rd      <= f_rd + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] mk(logic [CW-1:0] x0, logic [CW-1:0] y0,
                                       logic [CW-1:0] x1, logic [CW-1:0] y1,
                                       logic [COLW-1:0] c, logic v);
    return {x0, y0, x1, y1, c, v};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input int i, input int x, input int y,
                           input int c);
    check(tag, (wx[i] << 8) | (wy[i] << 4) | wc[i], (x << 8) | (y << 4) | c);
  endtask

  task automatic push(input logic [LW-1:0] w);
    fmem[f_wr[3:0]] = w;
    f_wr++;
  endtask

  task automatic sample();
    if (fb_wr_en && fb_ready && n_wr < 256) begin
      wx[n_wr] = int'(fb_x);
      wy[n_wr] = int'(fb_y);
      wc[n_wr] = int'(fb_color);
      n_wr++;
    end
    if (raster_done) n_done++;
  endtask

  task automatic cycle();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic start_frame(input logic clr);
    frame_start = 1'b1;
    clr_req     = clr;
    cycle();
    frame_start = 1'b0;
    clr_req     = 1'b0;
  endtask

  task automatic run_frame(input int max_cyc, output int used);
    used = 0;
    while (used < max_cyc) begin
      cycle();
      used++;
      if (!busy) break;
    end
  endtask

  int used;
  int bad;
  int n_stall;
  int stall_bad;
  logic prev_stall;
  logic [CW+CW+COLW:0] prev_out;

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_en", fb_wr_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_done", raster_done, 0);
    check("rst_xyc", {fb_x, fb_y, fb_color}, 0);
    @(negedge clk);
    rst = 1'b1;
    eoo = 1'b1;
    @(negedge clk);

    // Clear pass then empty FIFO with eoo
    n_wr = 0; n_done = 0;
    bk_color = 3'd5;
    start_frame(1'b1);
    run_frame(100, used);
    check("clr_cycles", used, 33);
    check("clr_writes", n_wr, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (wx[i] != i % 8 || wy[i] != i / 8 || wc[i] != 5) bad++;
    end
    check("clr_order", bad, 0);
    check("clr_done", n_done, 1);

    // Steep line
    n_wr = 0; n_done = 0;
    push(mk(4'd2, 4'd0, 4'd3, 4'd3, 3'd2, 1'b1));
    start_frame(1'b0);
    run_frame(50, used);
    check("steep_cycles", used, 7);
    check("steep_writes", n_wr, 4);
    check_pix("steep_p0", 0, 2, 0, 2);
    check_pix("steep_p1", 1, 2, 1, 2);
    check_pix("steep_p2", 2, 3, 2, 2);
    check_pix("steep_p3", 3, 3, 3, 2);
    check("steep_done", n_done, 1);

    // Backpressure: ready pattern 1,0,0 repeating
    n_wr = 0; n_done = 0; n_stall = 0; stall_bad = 0; prev_stall = 1'b0; prev_out = '0;
    push(mk(4'd1, 4'd1, 4'd5, 4'd1, 3'd3, 1'b1));
    start_frame(1'b0);
    for (int k = 0; k < 100; k++) begin
      fb_ready = (k % 3 == 0);
      #1;
      if (prev_stall && {fb_wr_en, fb_x, fb_y, fb_color} != prev_out) stall_bad++;
      prev_stall = fb_wr_en && !fb_ready;
      if (prev_stall) n_stall++;
      prev_out = {fb_wr_en, fb_x, fb_y, fb_color};
      sample();
      @(negedge clk);
      if (!busy) break;
    end
    fb_ready = 1'b1;
    check("bp_idle", busy, 0);
    check("bp_stalls_seen", int'(n_stall > 0), 1);
    check("bp_stable", stall_bad, 0);
    check("bp_writes", n_wr, 5);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (wx[i] != i + 1 || wy[i] != 1 || wc[i] != 3) bad++;
    end
    check("bp_order", bad, 0);

    // Invalid line followed by a line running off the right edge
    n_wr = 0; n_done = 0;
    push(mk(4'd1, 4'd1, 4'd2, 4'd2, 3'd1, 1'b0));
    push(mk(4'd6, 4'd0, 4'd9, 4'd0, 3'd4, 1'b1));
    start_frame(1'b0);
    run_frame(50, used);
    check("bnd_cycles", used, 9);
    check("bnd_writes", n_wr, 2);
    check_pix("bnd_p0", 0, 6, 0, 4);
    check_pix("bnd_p1", 1, 7, 0, 4);
    check("bnd_done", n_done, 1);

    // Point line then a right-to-left line
    n_wr = 0; n_done = 0;
    push(mk(4'd5, 4'd3, 4'd5, 4'd3, 3'd6, 1'b1));
    push(mk(4'd4, 4'd2, 4'd0, 4'd2, 3'd7, 1'b1));
    start_frame(1'b0);
    run_frame(50, used);
    check("rev_cycles", used, 11);
    check("rev_writes", n_wr, 6);
    check_pix("rev_point", 0, 5, 3, 6);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (wx[i + 1] != 4 - i || wy[i + 1] != 2 || wc[i + 1] != 7) bad++;
    end
    check("rev_order", bad, 0);

    // Reset in the middle of drawing
    n_wr = 0; n_done = 0;
    push(mk(4'd0, 4'd0, 4'd7, 4'd0, 3'd1, 1'b1));
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) cycle();
    #1;
    check("mid_busy", busy, 1);
    check("mid_wr_en", fb_wr_en, 1);
    rst = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_wr_en", fb_wr_en, 0);
    check("mr_xyc", {fb_x, fb_y, fb_color}, 0);
    check("mr_rd_done", {fifo_rd_en, raster_done}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("mr_no_done", n_done, 0);
    check("mr_writes", n_wr, 2);
    check("mr_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
